sobel_window_gen: RTL and testbench
===================================

# sobel_window_gen

Streaming 3x3 neighbourhood generator that feeds the deterministic Sobel core. It accepts a raster-order pixel stream through a valid/ready handshake and buffers two image rows. For every interior pixel it presents the nine-pixel window z1..z9 on a registered valid/ready output. It replaces the software window cropping the simulation flow uses today, so `sobel3x3det` can run on a live pixel stream.

## Interface
- `ROWS`, 436, image height in pixels (must be ≥3)
- `COLS`, 576, image width in pixels (must be ≥3)
- `DW`, 8, pixel width in bits
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pix_in`  in  DW  input pixel, raster order (row-major, top-left first)
- `pix_valid`  in  1  `pix_in` is valid
- `pix_ready`  out  1  block accepts `pix_in` this cycle
- `z1`..`z9`  out  DW each  window: z1..z3 row above, z4..z6 centre row, z7..z9 row below; left to right
- `win_valid`  out  1  window outputs are valid
- `win_ready`  in  1  consumer takes the window this cycle
- `win_last`  out  1  qualifies the final window of the frame

## Operation
- Input accept = `pix_valid && pix_ready`. Output accept = `win_valid && win_ready`.
- Column counter `col` runs 0..COLS-1. Row counter `row` runs 0..ROWS-1. Both advance only on input accept. Both wrap to 0 after (ROWS-1, COLS-1), and the next pixel starts a new frame.
- Two COLS-deep row delays hold rows r-1 and r-2. A 3x3 register array shifts one column per accepted pixel.
- A window is emitted on accept of pixel (r, c) with r≥2 and c≥2. Its centre is (r-1, c-1), and z9 equals the pixel just accepted.
- Windows per frame: (ROWS-2)*(COLS-2), in raster order of the centre pixel. No border windows are produced.
- `win_last` is high with the window whose centre is (ROWS-2, COLS-2).
- Output stage is one register: `pix_ready = !win_valid || win_ready`. A stalled window holds z1..z9 and `win_last` stable until accepted.
- Pixels that do not produce a window (r<2 or c<2) are accepted on the same `pix_ready` rule. They never assert `win_valid`.
- Reset values: `win_valid`=0, `win_last`=0, z1..z9=0. `row`=`col`=0, so `pix_ready`=1 one cycle after reset release.
- Line-buffer contents are not reset. Every location is overwritten before it is read.
- Reset mid-frame aborts the frame: the counters clear and the pending window is dropped. The next accepted pixel is pixel (0,0).

## Timing
- Latency: a window is visible one cycle after the accept of its z9 pixel.
- Throughput: one pixel per cycle, and one window per cycle in steady state with `win_ready` held high.
- Simultaneous output accept and new window generation in the same cycle: the new window loads, and `win_valid` stays 1.
- Backpressure: `win_ready`=0 while `win_valid`=1 forces `pix_ready`=0 in the same cycle (combinational path).
- No combinational path from `pix_valid` to any output.

## Configuration
- `SOBEL_WIN_COORD_EN` defined: adds two outputs, `win_row` and `win_col`.
  - Widths are $clog2(ROWS) and $clog2(COLS).
  - They carry the centre coordinates, are registered with z1..z9, and reset to 0.
- Undefined: both ports and their registers are absent, and all other behaviour is identical.

## Structure
- `sobel_pkg` holds:
  - `DW`
  - the default `ROWS`/`COLS`
  - `pixel_t` (logic [DW-1:0])
  - `window_t` (array of 9 `pixel_t`), shared with `sobel3x3det` wrappers and benches
- Sub-module `sobel_line_delay`: a COLS-deep, DW-wide single-row delay with an enable, instantiated twice.

## Test plan
All cases use `ROWS`=4, `COLS`=5 and pixel value = raster index.
- Basic frame, `win_ready`=1: stream 0..19 gapless. Expect exactly 6 windows.
  - First window: z1..z9 = 0,1,2,5,6,7,10,11,12, valid the cycle after pixel 12 is accepted.
  - Last window: 7,8,9,12,13,14,17,18,19 with `win_last`=1.
- Backpressure: hold `win_ready`=0 after the first window. `pix_ready` drops, and the window stays stable for 10 cycles. Release: the remaining 5 windows arrive in order with none lost or duplicated.
- Input bubbles: toggle `pix_valid` randomly (50%). The window values and count are identical to the basic frame.
- Back-to-back frames: stream 40 pixels. Expect 12 windows. The 7th window equals the 1st with `win_last`=0, and `win_last` is seen exactly twice.
- Reset mid-frame: pulse `reset` low after pixel 8, then stream 0..19. `win_valid`=0 during reset, and the output matches the basic frame exactly.
- With `SOBEL_WIN_COORD_EN`: the window coordinates run (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).

Source files
------------

// File: rtl/sobel_window_gen_pkg.sv
// sobel_pkg: shared types and defaults for the Sobel window generator,
// the sobel3x3det wrappers and their benches.
//   DW           pixel width in bits
//   ROWS_DEFAULT default image height
//   COLS_DEFAULT default image width
//   pixel_t      one pixel
//   window_t     nine pixels, index 0 = z1 (top-left) .. index 8 = z9 (bottom-right)
package sobel_pkg;

    localparam int DW           = 8;
    localparam int ROWS_DEFAULT = 436;
    localparam int COLS_DEFAULT = 576;

    typedef logic [DW-1:0] pixel_t;
    typedef pixel_t [8:0]  window_t;

endpackage

// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: pixel-in / window-out streams of sobel_window_gen.
//   pix_in, pix_valid, pix_ready           raster-order pixel stream
//   z1..z9, win_valid, win_ready, win_last 3x3 window stream
//   win_row, win_col                       window centre, only with SOBEL_WIN_COORD_EN
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holds its payload stable while valid is high and ready is low;
// ready may depend on the sink's state but never on the source's valid.
// Modports: slave = window generator, master = pixel source / window sink.
interface sobel_window_gen_if
    import sobel_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT
);

    pixel_t pix_in;
    logic   pix_valid;
    logic   pix_ready;
    pixel_t z1, z2, z3, z4, z5, z6, z7, z8, z9;
    logic   win_valid;
    logic   win_ready;
    logic   win_last;

`ifdef SOBEL_WIN_COORD_EN
    logic [$clog2(ROWS)-1:0] win_row;
    logic [$clog2(COLS)-1:0] win_col;

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9,
        output win_valid, win_last, win_row, win_col
    );
    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9,
        input  win_valid, win_last, win_row, win_col
    );
`else
    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9,
        output win_valid, win_last
    );
    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9,
        input  win_valid, win_last
    );
`endif

endinterface

// File: rtl/sobel_window_gen_line_delay.sv
// sobel_line_delay: one image row of delay (COLS pixels) with enable.
//   clk, reset  clock, asynchronous active-low reset (pointer only)
//   en          shift one pixel in
//   din         pixel entering the delay
//   dout        pixel that entered COLS enabled cycles ago
// The storage is not reset: every slot is written before it is read as
// part of a valid window.
module sobel_line_delay
    import sobel_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT
)(
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  pixel_t din,
    output pixel_t dout
);

    localparam int            AW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(COLS - 1);

    pixel_t        mem [COLS];
    logic [AW-1:0] ptr;

    // Read-before-write at the same slot gives exactly COLS of delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 neighbourhood generator for sobel3x3det.
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   io     sobel_window_gen_if.slave: pixel stream in, window stream out
// A window is emitted for every pixel (r,c) accepted with r>=2 and c>=2;
// it is centred on (r-1,c-1) and its z9 is the pixel just accepted.
// Optional feature macro SOBEL_WIN_COORD_EN adds win_row/win_col (centre).
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT
)(
    input  logic               clk,
    input  logic               reset,
    sobel_window_gen_if.slave  io
);

    localparam int            RW       = $clog2(ROWS);
    localparam int            CW       = $clog2(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          in_acc;
    logic          gen_win;
    logic          frame_end;

    pixel_t  above1;             // pixel (r-1, c)
    pixel_t  above2;             // pixel (r-2, c)
    pixel_t  top0, top1;         // row r-2, columns c-2 and c-1
    pixel_t  mid0, mid1;         // row r-1, columns c-2 and c-1
    pixel_t  bot0, bot1;         // row r,   columns c-2 and c-1
    window_t win_d;
    window_t win_q;
    logic    win_valid_q;
    logic    win_last_q;

    // Single output register: room for a new window when empty or draining.
    assign io.pix_ready = !win_valid_q || io.win_ready;
    assign in_acc       = io.pix_valid && io.pix_ready;
    assign gen_win      = in_acc && (row >= RW'(2)) && (col >= CW'(2));
    assign frame_end    = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (in_acc) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    sobel_line_delay #(.COLS(COLS)) u_delay1 (
        .clk   (clk),
        .reset (reset),
        .en    (in_acc),
        .din   (io.pix_in),
        .dout  (above1)
    );

    sobel_line_delay #(.COLS(COLS)) u_delay2 (
        .clk   (clk),
        .reset (reset),
        .en    (in_acc),
        .din   (above1),
        .dout  (above2)
    );

    // Only the two previous columns are stored; the third column of the
    // window is the live column {above2, above1, pix_in}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top0 <= '0; top1 <= '0;
            mid0 <= '0; mid1 <= '0;
            bot0 <= '0; bot1 <= '0;
        end else if (in_acc) begin
            top0 <= top1; top1 <= above2;
            mid0 <= mid1; mid1 <= above1;
            bot0 <= bot1; bot1 <= io.pix_in;
        end
    end

    assign win_d = {io.pix_in, bot1, bot0, above1, mid1, mid0, above2, top1, top0};

    // A new window wins over an output accept in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else if (gen_win) begin
            win_q       <= win_d;
            win_valid_q <= 1'b1;
            win_last_q  <= frame_end;
        end else if (io.win_ready) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else if (gen_win) begin
            win_row_q <= row - RW'(1);
            win_col_q <= col - CW'(1);
        end
    end

    assign io.win_row = win_row_q;
    assign io.win_col = win_col_q;
`endif

    assign io.z1        = win_q[0];
    assign io.z2        = win_q[1];
    assign io.z3        = win_q[2];
    assign io.z4        = win_q[3];
    assign io.z5        = win_q[4];
    assign io.z6        = win_q[5];
    assign io.z7        = win_q[6];
    assign io.z8        = win_q[7];
    assign io.z9        = win_q[8];
    assign io.win_valid = win_valid_q;
    assign io.win_last  = win_last_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen on a 4x5 image, pixel value = raster index.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int R    = 4;
    localparam int C    = 5;
    localparam int NPIX = R * C;
    localparam int EW   = 1 + 9 * DW;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sobel_window_gen_if #(.ROWS(R), .COLS(C)) bus ();

    sobel_window_gen #(.ROWS(R), .COLS(C)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
`ifdef SOBEL_WIN_COORD_EN
    logic [$clog2(R)+$clog2(C)-1:0] exp_rc_q[$];
`endif
    int   total;
    int   bad;
    int   n_win;
    int   n_last;
    logic prev_hold;

    typedef struct {
        int npix;
        int bubble;
        int exp_win;
        int exp_last;
    } case_t;

    case_t cases[3];

    function automatic logic [EW-1:0] model_win(input int f);
        logic [EW-1:0] e;
        int r;
        int c;
        r = f / C;
        c = f % C;
        e = '0;
        e[EW-1] = (r == R - 1) && (c == C - 1);
        for (int k = 0; k < 9; k++)
            e[(8 - k) * DW +: DW] = DW'((r - 2 + k / 3) * C + (c - 2 + k % 3));
        return e;
    endfunction

    function automatic logic [EW-1:0] dut_win();
        return {bus.win_last, bus.z1, bus.z2, bus.z3, bus.z4, bus.z5,
                bus.z6, bus.z7, bus.z8, bus.z9};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            ec;
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (bus.win_valid && !prev_hold) begin
                total = total + 1;
                if (exp_cyc_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL latency: window appeared at cycle %0d with none expected", cyc);
                end else begin
                    ec = exp_cyc_q.pop_front();
                    if (cyc != ec) begin
                        bad = bad + 1;
                        $display("FAIL latency: window at cycle %0d, required %0d", cyc, ec);
                    end
                end
            end
            if (bus.win_valid && bus.win_ready) begin
                total = total + 1;
                n_win = n_win + 1;
                if (bus.win_last) n_last = n_last + 1;
                if (exp_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL window: unexpected window got=%h", dut_win());
                end else begin
                    e = exp_q.pop_front();
                    if (dut_win() != e) begin
                        bad = bad + 1;
                        $display("FAIL window: got=%h required=%h", dut_win(), e);
                    end
                end
`ifdef SOBEL_WIN_COORD_EN
                total = total + 1;
                if (exp_rc_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL coord: no coordinate expected");
                end else begin
                    if ({bus.win_row, bus.win_col} != exp_rc_q[0]) begin
                        bad = bad + 1;
                        $display("FAIL coord: got=(%0d,%0d) required=%h",
                                 bus.win_row, bus.win_col, exp_rc_q[0]);
                    end
                    void'(exp_rc_q.pop_front());
                end
`endif
            end
            prev_hold = bus.win_valid && !bus.win_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pixels(input int n, input int bubble_pct);
        int idx;
        int guard;
        int f;
        idx   = 0;
        guard = 0;
        while (idx < n && guard < 4000) begin
            @(posedge clk);
            #1;
            bus.pix_valid = ($urandom_range(99) >= bubble_pct);
            bus.pix_in    = DW'(idx % NPIX);
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) begin
                f = idx % NPIX;
                if (f / C >= 2 && f % C >= 2) begin
                    exp_q.push_back(model_win(f));
                    exp_cyc_q.push_back(cyc + 1);
`ifdef SOBEL_WIN_COORD_EN
                    exp_rc_q.push_back({2'(f / C - 1), 3'(f % C - 1)});
`endif
                end
                idx++;
            end
            guard++;
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        total = total + 1;
        if (idx != n) begin
            bad = bad + 1;
            $display("FAIL send_timeout: sent=%0d required=%0d", idx, n);
        end
    endtask

    task automatic drain_and_count(input string name, input int want_win, input int want_last);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        total = total + 1;
        if (exp_q.size() != 0 || n_win != want_win || n_last != want_last) begin
            bad = bad + 1;
            $display("FAIL %s_count: windows=%0d lasts=%0d left=%0d required windows=%0d lasts=%0d left=0",
                     name, n_win, n_last, exp_q.size(), want_win, want_last);
        end
        n_win  = 0;
        n_last = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main ----------------
    initial begin
        logic [EW-1:0] snap;
        int            g;

        cases[0] = '{20, 0, 6, 1};
        cases[1] = '{20, 50, 6, 1};
        cases[2] = '{40, 0, 12, 2};

        total         = 0;
        bad           = 0;
        n_win         = 0;
        n_last        = 0;
        prev_hold     = 1'b0;
        cyc           = 0;
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.win_ready = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        total = total + 1;
        if (bus.win_valid !== 1'b0 || dut_win() !== '0) begin
            bad = bad + 1;
            $display("FAIL reset_state: valid=%b win=%h required valid=0 win=0", bus.win_valid, dut_win());
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        total = total + 1;
        if (bus.pix_ready !== 1'b1 || bus.win_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL post_reset: pix_ready=%b win_valid=%b required 1,0", bus.pix_ready, bus.win_valid);
        end

        // basic, bubbles, back-to-back frames
        for (int i = 0; i < 3; i++) begin
            send_pixels(cases[i].npix, cases[i].bubble);
            drain_and_count($sformatf("case%0d", i), cases[i].exp_win, cases[i].exp_last);
        end

        // backpressure: first window held for 10 cycles
        bus.win_ready = 1'b0;
        fork
            send_pixels(NPIX, 0);
            begin
                g = 0;
                while (!bus.win_valid && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                total = total + 1;
                if (!bus.win_valid) begin
                    bad = bad + 1;
                    $display("FAIL stall_wait: no window after %0d cycles", g);
                end
                snap = dut_win();
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    total = total + 1;
                    if (!bus.win_valid || bus.pix_ready || dut_win() != snap) begin
                        bad = bad + 1;
                        $display("FAIL stall_hold: valid=%b pix_ready=%b win=%h required 1,0,%h",
                                 bus.win_valid, bus.pix_ready, dut_win(), snap);
                    end
                end
                @(posedge clk);
                #1;
                bus.win_ready = 1'b1;
            end
        join
        drain_and_count("stall", 6, 1);

        // reset mid-frame after pixel 8
        send_pixels(9, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total = total + 1;
        if (bus.win_valid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL mid_reset: win_valid=%b required 0", bus.win_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_pixels(NPIX, 0);
        drain_and_count("after_reset", 6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
